// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 parallel-FIFO bridge.
package ft245_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWrPulse,
        StWrHold,
        StRdPulse,
        StRecover
    } ft245_state_e;

    // Bits needed for a counter that runs 0 .. max_count-1.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/ft245_tx_fifo.sv
// Synchronous byte FIFO buffering fabric TX data ahead of the FT245 write strobe.
module ft245_tx_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        wdata,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/ft245_stream.sv
// FT245 bridge: buffered TX byte stream, handshaked RX byte stream, WR/RD strobe timing FSM.
// Define FT245_RX_EN to build the host-to-fabric RD path; without it the bridge is TX only.
module ft245_stream
    import ft245_pkg::*;
#(
    parameter int unsigned TX_DEPTH      = 16,
    parameter int unsigned WR_PULSE_CYC  = 4,
    parameter int unsigned RD_PULSE_CYC  = 4,
    parameter int unsigned RD_SAMPLE_CYC = 3,
    parameter int unsigned RECOVERY_CYC  = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BYTE_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [BYTE_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    inout  wire  [BYTE_W-1:0]           D,
    output logic                        RD,
    output logic                        WR,
    input  logic                        TXE,
    input  logic                        RXF
);

    localparam int unsigned CNT_MAX_WR = (WR_PULSE_CYC > RD_PULSE_CYC) ? WR_PULSE_CYC
                                                                        : RD_PULSE_CYC;
    localparam int unsigned CNT_MAX    = (CNT_MAX_WR > RECOVERY_CYC) ? CNT_MAX_WR : RECOVERY_CYC;
    localparam int unsigned CNT_W      = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_SMPL  = CNT_W'(RD_SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY_CYC - 1);

    if (RECOVERY_CYC < SYNC_STAGES + 1) begin : g_bad_recovery
        $error("RECOVERY_CYC must be at least SYNC_STAGES+1");
    end
    if (RD_SAMPLE_CYC < 1 || RD_SAMPLE_CYC > RD_PULSE_CYC) begin : g_bad_sample
        $error("RD_SAMPLE_CYC must lie within the RD pulse");
    end

    ft245_state_e       state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_q, rd_q, d_oe_q;
    logic [BYTE_W-1:0]  d_out_q;
    logic               prefer_rd_q;
    logic               rx_pend_q, rx_valid_q;
    logic [BYTE_W-1:0]  rx_data_q;

    logic [SYNC_STAGES-1:0] txe_sync_q;
    logic                   txe_s, rxf_s;
    logic                   fifo_full, fifo_empty;
    logic [BYTE_W-1:0]      fifo_head;
    logic                   can_wr, can_rd, start_wr, start_rd;

    always_ff @(posedge clk) begin
        if (rst) txe_sync_q <= '1;
        else     txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], TXE};
    end
    assign txe_s = txe_sync_q[SYNC_STAGES-1];

`ifdef FT245_RX_EN
    localparam bit RX_EN = 1'b1;
    logic [SYNC_STAGES-1:0] rxf_sync_q;

    always_ff @(posedge clk) begin
        if (rst) rxf_sync_q <= '1;
        else     rxf_sync_q <= {rxf_sync_q[SYNC_STAGES-2:0], RXF};
    end
    assign rxf_s    = rxf_sync_q[SYNC_STAGES-1];
    assign RD       = rd_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`else
    localparam bit RX_EN = 1'b0;
    logic unused_rx;

    assign rxf_s     = 1'b1;
    assign RD        = 1'b1;
    assign rx_valid  = 1'b0;
    assign rx_data   = '0;
    assign unused_rx = ^{RXF, rx_ready, rd_q, rx_valid_q, rx_data_q};
`endif

    assign tx_ready = ~fifo_full & ~rst;

    ft245_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid & tx_ready),
        .wdata (tx_data),
        .pop   (start_wr),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (tx_level)
    );

    // Round-robin: when both directions are ready, serve the one not served last.
    assign can_wr   = ~fifo_empty & ~txe_s;
    assign can_rd   = RX_EN & ~rxf_s & ~rx_valid_q;
    assign start_wr = (state_q == StIdle) & can_wr & (~can_rd | ~prefer_rd_q);
    assign start_rd = (state_q == StIdle) & can_rd & ~start_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= '0;
            prefer_rd_q <= 1'b0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (start_wr) begin
                        state_q     <= StWrPulse;
                        wr_q        <= 1'b1;
                        d_oe_q      <= 1'b1;
                        d_out_q     <= fifo_head;
                        prefer_rd_q <= 1'b1;
                    end else if (start_rd) begin
                        state_q     <= StRdPulse;
                        rd_q        <= 1'b0;
                        prefer_rd_q <= 1'b0;
                    end
                end
                StWrPulse: begin
                    if (cnt_q == WR_LAST) begin
                        state_q <= StWrHold;
                        wr_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrHold: begin
                    state_q <= StRecover;
                    d_oe_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                StRdPulse: begin
                    if (cnt_q == RD_SMPL) rx_data_q <= D;
                    if (cnt_q == RD_LAST) begin
                        state_q   <= StRecover;
                        rd_q      <= 1'b1;
                        rx_pend_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRecover: begin
                    if (rx_pend_q) begin
                        rx_valid_q <= 1'b1;
                        rx_pend_q  <= 1'b0;
                    end
                    if (cnt_q == REC_LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign WR = wr_q;
    assign D  = d_oe_q ? d_out_q : {BYTE_W{1'bz}};

endmodule

// File: tb/tb_ft245_stream.sv
// Scoreboard bench for ft245_stream: a chip-side monitor checks strobe timing and data against
// queues filled by the stimulus model. Covers the RX path only when FT245_RX_EN is defined.
module tb_ft245_stream;
    import ft245_pkg::*;

    localparam int TX_DEPTH      = 16;
    localparam int WR_PULSE_CYC  = 4;
    localparam int RD_PULSE_CYC  = 4;
    localparam int RD_SAMPLE_CYC = 3;
    localparam int RECOVERY_CYC  = 4;
    localparam int SYNC_STAGES   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [4:0] tx_level;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    wire  [7:0] D;
    logic       RD, WR;
    logic       TXE = 1'b1;
    logic       RXF = 1'b1;

    logic       tb_d_oe = 1'b0;
    logic [7:0] tb_d = 8'h00;
    assign D = tb_d_oe ? tb_d : 8'hzz;

    always #5 clk = ~clk;

    ft245_stream #(
        .TX_DEPTH      (TX_DEPTH),
        .WR_PULSE_CYC  (WR_PULSE_CYC),
        .RD_PULSE_CYC  (RD_PULSE_CYC),
        .RD_SAMPLE_CYC (RD_SAMPLE_CYC),
        .RECOVERY_CYC  (RECOVERY_CYC),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_level (tx_level),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .D        (D),
        .RD       (RD),
        .WR       (WR),
        .TXE      (TXE),
        .RXF      (RXF)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: bytes the chip should see, bytes fabric should receive.
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    bit         strobes[$];   // 0 = WR, 1 = RD
    int         lvl = 0;
    int         wr_hi = 0, gap = 0, rd_lo = 0, rd_since_rise = 100;
    int         wr_rises = 0, rd_falls = 0;
    bit         have_prev = 0, wr_prev = 0, rd_prev = 1, rst_prev = 1, rxv_prev = 0;
    logic [7:0] d_hi = 8'h00;
    logic [7:0] rx_next = 8'h3C;
    logic [7:0] txe_hist = 8'hFF;

    always @(negedge clk) begin
        txe_hist = {txe_hist[6:0], TXE};
        if (WR && !wr_prev) begin
            // TXE as sampled by the first sync stage three samples back decided this start.
            check("wr_only_when_txe_low", int'(txe_hist[SYNC_STAGES + 1]), 0);
            if (have_prev) check("recovery_gap", int'(gap >= RECOVERY_CYC + 1), 1);
            lvl--;
            wr_rises++;
            strobes.push_back(1'b0);
        end
        if (!RD && rd_prev) begin
            if (have_prev) check("recovery_gap", int'(gap >= RECOVERY_CYC + 1), 1);
            rd_falls++;
            strobes.push_back(1'b1);
        end
        if (WR) begin
            wr_hi++;
            d_hi = D;
        end
        if (!WR && wr_prev) begin
            if (rst_prev) begin
                check("wr_truncated_undriven", int'(dut.d_oe_q), 0);
            end else begin
                check("wr_pulse_width", wr_hi, WR_PULSE_CYC);
                check("wr_hold_drive", int'(dut.d_oe_q), 1);
                check("wr_expected", int'(tx_exp.size() > 0), 1);
                if (tx_exp.size() > 0) begin
                    check("wr_data_before_fall", int'(d_hi), int'(tx_exp[0]));
                    check("wr_data_after_fall", int'(D), int'(tx_exp[0]));
                    void'(tx_exp.pop_front());
                end
            end
            wr_hi = 0;
            have_prev = 1;
            gap = 0;
        end
        if (RD && !rd_prev) begin
            check("rd_pulse_width", rd_lo, RD_PULSE_CYC);
            have_prev = 1;
            gap = 0;
            rd_since_rise = 0;
        end else begin
            rd_since_rise++;
        end
        if (!WR && RD) gap++;
        rd_lo = RD ? 0 : rd_lo + 1;

        // Chip model: present a byte on D from the second RD-low cycle until RD returns high.
        if (!RD && rd_lo == 2) begin
            tb_d = rx_next;
            tb_d_oe = 1'b1;
            rx_exp.push_back(rx_next);
            rx_next = 8'($urandom);
        end
        if (RD) tb_d_oe = 1'b0;

        if (rx_valid && !rxv_prev) begin
            check("rx_valid_after_rd_rise", rd_since_rise, 1);
            check("rx_valid_expected", int'(rx_exp.size() > 0), 1);
        end
        if (rx_valid && rx_ready && !rst && rx_exp.size() > 0) begin
            check("rx_data", int'(rx_data), int'(rx_exp[0]));
            void'(rx_exp.pop_front());
        end

        check("tx_ready", int'(tx_ready), int'(!rst && lvl < TX_DEPTH));
        check("tx_level", int'(tx_level), lvl);
        check("wr_rd_exclusive", int'(WR && !RD), 0);
`ifndef FT245_RX_EN
        check("rd_idle_no_rx", int'(RD), 1);
        check("rx_valid_no_rx", int'(rx_valid), 0);
`endif
        if (rst) begin
            lvl = 0;
            tx_exp.delete();
            rx_exp.delete();
            have_prev = 0;
            tb_d_oe = 1'b0;
        end else if (tx_valid && lvl < TX_DEPTH) begin
            tx_exp.push_back(tx_data);
            lvl++;
        end
        wr_prev = WR;
        rd_prev = RD;
        rst_prev = rst;
        rxv_prev = rx_valid;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        check("drain_complete", tx_exp.size() + rx_exp.size(), 0);
        cyc(RECOVERY_CYC + 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        cyc(2);
        check("reset_wr", int'(WR), 0);
        check("reset_rd", int'(RD), 1);
        check("reset_d_undriven", int'(dut.d_oe_q), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_tx_ready", int'(tx_ready), 0);
        check("reset_tx_level", int'(tx_level), 0);
        rst = 1'b0;
        cyc(4);

        // Two bytes queued while the chip is busy, then released.
        push_byte(8'h55);
        push_byte(8'hAA);
        cyc(1);
        check("level_two", int'(tx_level), 2);
        TXE = 1'b0;
        drain(200);
        check("level_drained", int'(tx_level), 0);

        // Fill the buffer with the chip busy; the 17th push must be dropped.
        TXE = 1'b1;
        cyc(3);
        snap = wr_rises;
        for (int i = 0; i < TX_DEPTH + 1; i++) push_byte(8'($urandom));
        check("full_tx_ready", int'(tx_ready), 0);
        check("full_tx_level", int'(tx_level), TX_DEPTH);
        cyc(30);
        check("no_wr_while_txe_high", wr_rises, snap);
        TXE = 1'b0;
        drain(600);

`ifdef FT245_RX_EN
        // One byte from the host, consumer stalled: exactly one RD pulse.
        snap = rd_falls;
        rx_next = 8'h3C;
        RXF = 1'b0;
        cyc(40);
        check("rx_held_valid", int'(rx_valid), 1);
        check("rx_held_data", int'(rx_data), 8'h3C);
        check("single_rd_while_stalled", rd_falls - snap, 1);
        RXF = 1'b1;
        cyc(4);
        rx_ready = 1'b1;
        drain(100);
        check("rx_valid_cleared", int'(rx_valid), 0);

        // Both directions pending: strobes must alternate.
        TXE = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        cyc(4);
        strobes.delete();
        TXE = 1'b0;
        RXF = 1'b0;
        n = 0;
        while (strobes.size() < 8 && n < 400) begin
            cyc(1);
            n++;
        end
        RXF = 1'b1;
        check("alternation_strobes_seen", int'(strobes.size() >= 8), 1);
        for (int i = 1; i < 8 && i < strobes.size(); i++)
            check("strobe_alternates", int'(strobes[i] != strobes[i-1]), 1);
        drain(400);
`else
        // RX path absent: RXF asserted must never produce a read.
        snap = rd_falls;
        RXF = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rx_ready = 1'($urandom);
            cyc(1);
        end
        check("no_rd_without_rx", rd_falls - snap, 0);
        RXF = 1'b1;
`endif

        // Randomised traffic with flag toggling.
        for (int i = 0; i < 600; i++) begin
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            if ($urandom_range(7) == 0) TXE = ~TXE;
            if ($urandom_range(9) == 0) RXF = ~RXF;
            rx_ready = ($urandom_range(3) != 0);
            cyc(1);
        end
        tx_valid = 1'b0;
        TXE = 1'b0;
        RXF = 1'b1;
        rx_ready = 1'b1;
        drain(2000);

        // Reset in the second cycle of a WR pulse aborts the transfer.
        TXE = 1'b1;
        cyc(4);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        TXE = 1'b0;
        n = 0;
        while (!WR && n < 200) begin
            cyc(1);
            n++;
        end
        check("wr_start_before_reset", int'(WR), 1);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check("abort_wr_low", int'(WR), 0);
        check("abort_d_undriven", int'(dut.d_oe_q), 0);
        check("abort_tx_level", int'(tx_level), 0);
        check("abort_state_idle", int'(dut.state_q == StIdle), 1);
        cyc(1);
        rst = 1'b0;
        push_byte(8'h5A);
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
